// File: rtl/mul_div_unit_pkg.sv
// Shared widths, opcodes, state encoding and helpers for the multiply/divide unit.
package mul_div_unit_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned MUL_DIV_OP_W   = 2;
  localparam int unsigned MD_ITER        = 32;
  localparam int unsigned MD_CNT_W       = $clog2(MD_ITER);

  typedef logic [DATA_W-1:0]       DataPath;
  typedef logic [MUL_DIV_OP_W-1:0] MulDivOpPath;

  // op[1] selects divide, op[0] selects signed operation
  typedef enum logic [MUL_DIV_OP_W-1:0] {
    MD_OP_MULTU = 2'b00,
    MD_OP_MULT  = 2'b01,
    MD_OP_DIVU  = 2'b10,
    MD_OP_DIV   = 2'b11
  } mdOpT;

  typedef enum logic [1:0] {
    MD_ST_IDLE,
    MD_ST_CALC,
    MD_ST_FIXUP,
    MD_ST_DONE
  } mdStateT;

  // Conditional two's-complement negate (magnitude extraction and sign fixup)
  function automatic DataPath mdNeg(input DataPath v, input logic neg);
    return neg ? DataPath'(-v) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide, one bit per cycle, with HI/LO result registers.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MUL_DIV_OP_W-1:0] op,
  input  logic [DATA_W-1:0]       srcA,
  input  logic [DATA_W-1:0]       srcB,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_W-1:0]       hi,
  output logic [DATA_W-1:0]       lo,
  output logic                    divByZero
);

  localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(MD_ITER - 1);

  mdStateT             state;
  logic [MD_CNT_W-1:0] cnt;
  logic [2*DATA_W-1:0] acc;
  DataPath             opB;
  logic                isDivR;
  logic                dzR;
  logic                negQ;
  logic                negR;

  logic    accept;
  logic    inIsDiv;
  logic    inSigned;
  logic    inSignA;
  logic    inSignB;
  logic    inDz;
  DataPath absA;
  DataPath absB;

  // Decode the incoming request and form operand magnitudes
  always_comb begin
    accept   = start && (state == MD_ST_IDLE || state == MD_ST_DONE);
    inIsDiv  = (mdOpT'(op) == MD_OP_DIVU) || (mdOpT'(op) == MD_OP_DIV);
    inSigned = (mdOpT'(op) == MD_OP_MULT) || (mdOpT'(op) == MD_OP_DIV);
    inSignA  = inSigned && srcA[DATA_W-1];
    inSignB  = inSigned && srcB[DATA_W-1];
    inDz     = inIsDiv && (srcB == '0);
    absA     = mdNeg(srcA, inSignA);
    absB     = mdNeg(srcB, inSignB);
  end

  logic [DATA_W:0]     addA;
  logic [DATA_W:0]     addB;
  logic                addCin;
  logic [DATA_W+1:0]   addSum;
  logic [2*DATA_W-1:0] accNext;

  // Shared adder: multiply adds the multiplicand into the upper half, divide
  // subtracts the divisor from the shifted partial remainder (carry-out = no borrow)
  always_comb begin
    if (isDivR) begin
      addA   = acc[2*DATA_W-1:DATA_W-1];
      addB   = ~{1'b0, opB};
      addCin = 1'b1;
    end else begin
      addA   = {1'b0, acc[2*DATA_W-1:DATA_W]};
      addB   = acc[0] ? {1'b0, opB} : '0;
      addCin = 1'b0;
    end
    addSum = {1'b0, addA} + {1'b0, addB} + (DATA_W+2)'(addCin);
    if (isDivR) begin
      accNext = addSum[DATA_W+1] ? {addSum[DATA_W-1:0], acc[DATA_W-2:0], 1'b1}
                                 : {acc[2*DATA_W-2:0], 1'b0};
    end else begin
      accNext = {addSum[DATA_W:0], acc[DATA_W-1:1]};
    end
  end

  logic [2*DATA_W-1:0] prodFix;
  DataPath             hiFix;
  DataPath             loFix;

  // Apply result signs; a divide-by-zero result was preloaded raw into acc
  always_comb begin
    prodFix = negQ ? (2*DATA_W)'(-acc) : acc;
    if (dzR) begin
      hiFix = acc[2*DATA_W-1:DATA_W];
      loFix = acc[DATA_W-1:0];
    end else if (isDivR) begin
      hiFix = mdNeg(acc[2*DATA_W-1:DATA_W], negR);
      loFix = mdNeg(acc[DATA_W-1:0], negQ);
    end else begin
      hiFix = prodFix[2*DATA_W-1:DATA_W];
      loFix = prodFix[DATA_W-1:0];
    end
  end

  // Control FSM, iteration counter, accumulator and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MD_ST_IDLE;
      cnt       <= '0;
      acc       <= '0;
      opB       <= '0;
      isDivR    <= 1'b0;
      dzR       <= 1'b0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Divide by zero bypasses CALC: preload the raw result for FIXUP
        acc       <= inDz ? {srcA, {DATA_W{1'b1}}} : {{DATA_W{1'b0}}, absA};
        opB       <= absB;
        isDivR    <= inIsDiv;
        dzR       <= inDz;
        negQ      <= inSignA ^ inSignB;
        negR      <= inSignA;
        cnt       <= '0;
        busy      <= 1'b1;
        divByZero <= 1'b0;
        state     <= inDz ? MD_ST_FIXUP : MD_ST_CALC;
      end else begin
        case (state)
          MD_ST_CALC: begin
            acc <= accNext;
            if (cnt == CNT_LAST) begin
              state <= MD_ST_FIXUP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          MD_ST_FIXUP: begin
            hi        <= hiFix;
            lo        <= loFix;
            divByZero <= dzR;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= MD_ST_DONE;
          end
          MD_ST_DONE: state <= MD_ST_IDLE;
          default:    state <= MD_ST_IDLE;
        endcase
      end
    end
  end

endmodule
